// File: rtl/mux_2x1_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mux_2x1_arbiter (with leaf mux_2x1_1bit)
// Brief   : Round-robin 2-requester arbiter steering a WIDTH-bit 2:1 mux.
//           Optional grant hold limit: define ARB_HOLD_LIMIT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mux_2x1_1bit (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module mux_2x1_arbiter #(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;
  logic   last_q, last_d;
  logic   hold_expired;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HOLD_W = $clog2(HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Counts cycles of continuous ownership; saturates so an uncontested owner keeps the bus.
  always_comb begin
    hold_d = hold_q;
    if (state_d != state_q || state_q == IDLE) begin
      hold_d = '0;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign hold_expired = (hold_q == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (req1 && (!req0 || hold_expired)) begin
          state_d = OWN1;
        end else if (!req0) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        if (req0 && (!req1 || hold_expired)) begin
          state_d = OWN0;
        end else if (!req1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // sel and last-served only move when a requester takes ownership; IDLE keeps them.
  always_comb begin
    sel_d  = sel_q;
    last_d = last_q;
    if (state_d == OWN0) begin
      sel_d  = 1'b0;
      last_d = 1'b0;
    end else if (state_d == OWN1) begin
      sel_d  = 1'b1;
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign sel       = sel_q;
  assign out_valid = gnt0 | gnt1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2x1_1bit u_mux (
      .a (in0[i]),
      .b (in1[i]),
      .s (sel_q),
      .y (out[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_2x1_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mux_2x1_arbiter
// Brief   : Directed self-checking bench for mux_2x1_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mux_2x1_arbiter;

  localparam int WIDTH    = 4;
  localparam int HOLD_MAX = 4;

  logic             clk;
  logic             rst_n;
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  mux_2x1_arbiter #(
    .WIDTH    (WIDTH),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .in0       (in0),
    .in1       (in1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic e_g0, input logic e_g1,
                              input logic e_sel);
    check_eq({tag, ".gnt0"}, 32'(gnt0), 32'(e_g0));
    check_eq({tag, ".gnt1"}, 32'(gnt1), 32'(e_g1));
    check_eq({tag, ".sel"}, 32'(sel), 32'(e_sel));
    check_eq({tag, ".valid"}, 32'(out_valid), 32'(e_g0 | e_g1));
    check_eq({tag, ".out"}, 32'(out), 32'(e_sel ? in1 : in0));
  endtask

  initial begin
    logic exp_g0;

    rst_n = 1'b0;
    req0  = 1'b1;
    req1  = 1'b1;
    in0   = 4'hA;
    in1   = 4'h5;

    // 1: reset values visible before any clock edge
    #3;
    expect_state("rst_noclk", 1'b0, 1'b0, 1'b0);
    #9 rst_n = 1'b1;
    tick();
    expect_state("rst_first", 1'b1, 1'b0, 1'b0);

    // 2: lone req0 burst, then release
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    expect_state("idle0", 1'b0, 1'b0, 1'b0);
    req0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_state("burst0", 1'b1, 1'b0, 1'b0);
    end
    in0 = 4'h3;
    #1;
    check_eq("comb_out", 32'(out), 32'h3);
    req0 = 1'b0;
    tick();
    expect_state("burst0_end", 1'b0, 1'b0, 1'b0);

    // 3: restore favour for requester 0, then tie, handover, re-tie
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    expect_state("tie_a", 1'b1, 1'b0, 1'b0);
    req0 = 1'b0;
    tick();
    expect_state("hand_1", 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    tick();
    expect_state("idle_sel_hold", 1'b0, 1'b0, 1'b1);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    expect_state("tie_b", 1'b1, 1'b0, 1'b0);

    // 4: simultaneous drop/raise hands over with no idle bubble
    req0 = 1'b0;
    tick();
    expect_state("own1", 1'b0, 1'b1, 1'b1);
    req1 = 1'b0;
    req0 = 1'b1;
    tick();
    expect_state("swap_0", 1'b1, 1'b0, 1'b0);

    // tie from IDLE after requester 0 was served goes to requester 1
    req0 = 1'b0;
    tick();
    expect_state("idle2", 1'b0, 1'b0, 1'b0);
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    expect_state("tie_rr", 1'b0, 1'b1, 1'b1);

    // 6: asynchronous reset mid-grant during OWN1
    #2 rst_n = 1'b0;
    #1;
    expect_state("async_rst", 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    tick();
    expect_state("post_rst", 1'b1, 1'b0, 1'b0);

    // 5: both held high; cycle 0 of ownership already checked above
    for (int k = 1; k < 24; k++) begin
      tick();
`ifdef ARB_HOLD_LIMIT_EN
      exp_g0 = ((k / HOLD_MAX) % 2) == 0;
`else
      exp_g0 = 1'b1;
`endif
      expect_state($sformatf("hold_%0d", k), exp_g0, !exp_g0, !exp_g0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
